uart_rx_deserializer: RTL

- Serial receive front end for the memory-mapped UART component; it sits directly upstream of the component's Rx buffer.
- Synchronises the asynchronous rx_in pin and detects and validates start bits.
- Mid-bit samples an 8N1 frame, LSB first, and presents the byte with one-cycle rx_complete and rx_start strobes.
- Flags framing errors and rejects glitches.

---
 rtl/uart_rx_deserializer_if.sv | 24 ++
 rtl/uart_rx_deserializer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer_if.sv
// Serial receive port bundle: the line input plus the byte and strobes
// handed to the downstream Rx buffer.
interface uart_rx_deserializer_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_in;
  logic [DATA_BITS-1:0] rx_byte;
  logic                 rx_start;
  logic                 rx_complete;
  logic                 frame_error;
  logic                 busy;

  // Line driver / byte consumer side
  modport master (
    output rx_in,
    input  rx_byte, rx_start, rx_complete, frame_error, busy
  );

  // Deserializer side
  modport slave (
    input  rx_in,
    output rx_byte, rx_start, rx_complete, frame_error, busy
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receive front end: two-flop synchroniser, start-bit validation
// at half a bit period, single mid-bit sampling of data and stop bits, and
// one-cycle strobes for start, completion and framing error.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input logic                   clock,
  input logic                   reset,
  uart_rx_deserializer_if.slave rx_if
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t               state_reg, state_next;
  logic                 sync1_reg, sync2_reg;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] rx_byte_reg, rx_byte_next;
  logic                 rx_start_reg, rx_start_next;
  logic                 rx_complete_reg, rx_complete_next;
  logic                 frame_error_reg, frame_error_next;
  logic                 busy_reg, busy_next;
  logic                 rx_s;
  logic                 data_sample;

  assign rx_s = sync2_reg;

  // A data bit is captured on the last count of each data bit period
  assign data_sample = (state_reg == DATA) && (cnt_reg == BIT_M1);

  // Each shift bit only loads when the bit index points at it (LSB first)
  generate
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
      assign shift_next[gi] = (data_sample && (idx_reg == IDX_W'(gi)))
                              ? rx_s : shift_reg[gi];
    end
  endgenerate

  // Synchroniser, FSM state and output registers; line idles high in reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_reg       <= 1'b1;
      sync2_reg       <= 1'b1;
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      idx_reg         <= '0;
      shift_reg       <= '0;
      rx_byte_reg     <= '0;
      rx_start_reg    <= 1'b0;
      rx_complete_reg <= 1'b0;
      frame_error_reg <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      sync1_reg       <= rx_if.rx_in;
      sync2_reg       <= sync1_reg;
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      idx_reg         <= idx_next;
      shift_reg       <= shift_next;
      rx_byte_reg     <= rx_byte_next;
      rx_start_reg    <= rx_start_next;
      rx_complete_reg <= rx_complete_next;
      frame_error_reg <= frame_error_next;
      busy_reg        <= busy_next;
    end
  end

  // Next-state and output decode; strobes default low so they last one cycle
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    idx_next         = idx_reg;
    rx_byte_next     = rx_byte_reg;
    rx_start_next    = 1'b0;
    rx_complete_next = 1'b0;
    frame_error_next = 1'b0;
    busy_next        = busy_reg;

    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = '0;
        end
      end

      START: begin
        if (cnt_reg == HALF_M1) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next    = DATA;
            idx_next      = '0;
            rx_start_next = 1'b1;
            busy_next     = 1'b1;
          end else begin
            // Low pulse shorter than half a bit: treat as a glitch
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DATA: begin
        if (cnt_reg == BIT_M1) begin
          cnt_next = '0;
          if (idx_reg == LAST_IDX) begin
            state_next = STOP;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      STOP: begin
        if (cnt_reg == BIT_M1) begin
          cnt_next  = '0;
          busy_next = 1'b0;
          if (rx_s) begin
            // Returning to IDLE at mid-stop lets a back-to-back start be caught
            state_next       = IDLE;
            rx_byte_next     = shift_reg;
            rx_complete_next = 1'b1;
          end else begin
            state_next       = BREAK;
            frame_error_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      BREAK: begin
        // Wait out a held-low line so it reports only one framing error
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rx_if.rx_byte     = rx_byte_reg;
  assign rx_if.rx_start    = rx_start_reg;
  assign rx_if.rx_complete = rx_complete_reg;
  assign rx_if.frame_error = frame_error_reg;
  assign rx_if.busy        = busy_reg;

endmodule
